// File: rtl/skinny_inv_sbox_pipe.sv
// 3-share masked inverse SKINNY-64 S-box as two registered quadratic layers with valid/stall control.
// Optional build macro SKINNY_INV_SBOX_RC_EN adds rc_i, which is XORed into share 1 before inversion.
module skinny_inv_sbox_pipe #(
   parameter int NSHARE = 3,
   parameter int RW     = 12
) (
   input  logic            clk,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            in_valid_i,
   input  logic [3:0]      in1,
   input  logic [3:0]      in2,
   input  logic [3:0]      in3,
`ifdef SKINNY_INV_SBOX_RC_EN
   input  logic [3:0]      rc_i,
`endif
   input  logic [2*RW-1:0] r,
   output logic            out_valid_o,
   output logic [3:0]      out1,
   output logic [3:0]      out2,
   output logic [3:0]      out3,
   output logic [1:0]      occ_o
);

   generate
      if (NSHARE != 3 || RW != 12) begin : g_bad_cfg
         $error("skinny_inv_sbox_pipe supports only NSHARE=3 and RW=12");
      end
   endgenerate

   // Sinv is the NOR chain y0^=~(y3|y2); y1^=~(y0|y3); y2^=~(y1|y0); y3^=~(y2|y1)
   // followed by the output permutation (y2,y1,y0,y3). Layer 1 covers the first two steps,
   // layer 2 the last two; each pair collapses to a quadratic map. Every output bit is
   // written as lin ^ a&b with per-share linear lin/a/b, so one DOM product per bit.
   function automatic logic [3:0] l1_lin(input logic [3:0] s, input logic c);
      l1_lin = {s[3], s[2], s[1] ^ s[0] ^ s[2], s[0] ^ s[3] ^ s[2] ^ c};
   endfunction

   function automatic logic [3:0] l1_a(input logic [3:0] s);
      l1_a = {2'b00, s[3], s[3]};
   endfunction

   function automatic logic [3:0] l1_b(input logic [3:0] s);
      l1_b = {2'b00, s[2] ^ s[0], s[2]};
   endfunction

   function automatic logic [3:0] l2_lin(input logic [3:0] u, input logic c);
      l2_lin = {u[3] ^ u[2] ^ u[0], u[2] ^ u[1] ^ u[0] ^ c, u[1], u[0]};
   endfunction

   function automatic logic [3:0] l2_a(input logic [3:0] u);
      l2_a = {u[1], u[1], 2'b00};
   endfunction

   function automatic logic [3:0] l2_b(input logic [3:0] u);
      l2_b = {u[0] ^ u[2], u[0], 2'b00};
   endfunction

   // Mask nibble for share pair p (0:{1,2} 1:{1,3} 2:{2,3}); bit k uses rr[3k+p].
   function automatic logic [3:0] rnib(input logic [11:0] rr, input int p);
      rnib = {rr[9+p], rr[6+p], rr[3+p], rr[p]};
   endfunction

   logic [3:0]  rc_p0;
   logic [3:0]  x_p0   [3];
   logic [3:0]  lin_p0 [3];
   logic [3:0]  a_p0   [3];
   logic [3:0]  b_p0   [3];
   logic [3:0]  t_p0   [3][3];
   logic [11:0] r1_p0;
   logic [11:0] r2_p1;

   logic [3:0]  t_p1   [3][3];
   logic [3:0]  u_p1   [3];
   logic [3:0]  lin_p1 [3];
   logic [3:0]  a_p1   [3];
   logic [3:0]  b_p1   [3];
   logic [3:0]  tn_p1  [3][3];
   logic        vld_p1;

   logic [3:0]  t_p2   [3][3];
   logic [3:0]  w_p2   [3];
   logic        vld_p2;

`ifdef SKINNY_INV_SBOX_RC_EN
   assign rc_p0 = rc_i;
`else
   assign rc_p0 = 4'h0;
`endif

   assign r1_p0 = r[RW-1:0];
   assign r2_p1 = r[2*RW-1:RW];

   // Stage 0: constant removal on share 1, layer-1 terms (each reads at most shares i and j)
   always_comb begin
      x_p0[0] = in1 ^ rc_p0;
      x_p0[1] = in2;
      x_p0[2] = in3;
      for (int i = 0; i < 3; i++) begin
         lin_p0[i] = l1_lin(x_p0[i], (i == 0));
         a_p0[i]   = l1_a(x_p0[i]);
         b_p0[i]   = l1_b(x_p0[i]);
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (i == j)
               t_p0[i][j] = lin_p0[i] ^ (a_p0[i] & b_p0[i]);
            else
               t_p0[i][j] = (a_p0[i] & b_p0[j]) ^ rnib(r1_p0, i + j - 1);
         end
      end
   end

   // Bank A
   always_ff @(posedge clk) begin
      if (rst_i) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               t_p1[i][j] <= 4'h0;
      end else if (!stall_i) begin
         vld_p1 <= in_valid_i;
         t_p1   <= t_p0;
      end
   end

   // Stage 1: per-share compression, then layer-2 terms
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         u_p1[i]   = t_p1[i][0] ^ t_p1[i][1] ^ t_p1[i][2];
         lin_p1[i] = l2_lin(u_p1[i], (i == 0));
         a_p1[i]   = l2_a(u_p1[i]);
         b_p1[i]   = l2_b(u_p1[i]);
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (i == j)
               tn_p1[i][j] = lin_p1[i] ^ (a_p1[i] & b_p1[i]);
            else
               tn_p1[i][j] = (a_p1[i] & b_p1[j]) ^ rnib(r2_p1, i + j - 1);
         end
      end
   end

   // Bank B
   always_ff @(posedge clk) begin
      if (rst_i) begin
         vld_p2 <= 1'b0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               t_p2[i][j] <= 4'h0;
      end else if (!stall_i) begin
         vld_p2 <= vld_p1;
         t_p2   <= tn_p1;
      end
   end

   // Stage 2: compression and output bit permutation
   always_comb begin
      for (int i = 0; i < 3; i++)
         w_p2[i] = t_p2[i][0] ^ t_p2[i][1] ^ t_p2[i][2];
   end

   assign out1        = {w_p2[0][2], w_p2[0][1], w_p2[0][0], w_p2[0][3]};
   assign out2        = {w_p2[1][2], w_p2[1][1], w_p2[1][0], w_p2[1][3]};
   assign out3        = {w_p2[2][2], w_p2[2][1], w_p2[2][0], w_p2[2][3]};
   assign out_valid_o = vld_p2;
   assign occ_o       = {1'b0, vld_p1} + {1'b0, vld_p2};

endmodule
